mrd_rdx5_sched: RTL and testbench

//  Burst-level scheduler that shares one radix-5 butterfly engine (5 complex samples per beat,

---
 rtl/mrd_rdx5_sched_if.sv | 39 +++
 rtl/mrd_rdx5_sched.sv | 114 +++++++++++
 tb/tb_mrd_rdx5_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mrd_rdx5_sched_if.sv
// Signal bundle between the radix-5 burst scheduler, its two stage requesters and the shared engine.
// The scheduler attaches through the slave modport; the requester/engine side uses master.
interface mrd_rdx5_sched_if #(parameter int LEN_W = 8);
    logic [1:0]       req;
    logic [LEN_W-1:0] req_len0;
    logic [LEN_W-1:0] req_len1;
    logic [1:0]       req_margin0;
    logic [1:0]       req_margin1;
    logic [3:0]       req_exp0;
    logic [3:0]       req_exp1;
    logic [1:0]       src_val;
    logic [1:0]       gnt;
    logic             eng_in_val;
    logic             eng_sel;
    logic [1:0]       eng_margin;
    logic [3:0]       eng_exp_in;
    logic             eng_out_val;
    logic [3:0]       eng_exp_out;
    logic [1:0]       res_val;
    logic [1:0]       res_last;
    logic [3:0]       res_exp;
    logic [1:0]       done;
    logic             busy;
    logic             err_tag;

    modport slave (
        input  req, req_len0, req_len1, req_margin0, req_margin1, req_exp0, req_exp1,
               src_val, eng_out_val, eng_exp_out,
        output gnt, eng_in_val, eng_sel, eng_margin, eng_exp_in,
               res_val, res_last, res_exp, done, busy, err_tag
    );

    modport master (
        output req, req_len0, req_len1, req_margin0, req_margin1, req_exp0, req_exp1,
               src_val, eng_out_val, eng_exp_out,
        input  gnt, eng_in_val, eng_sel, eng_margin, eng_exp_in,
               res_val, res_last, res_exp, done, busy, err_tag
    );
endinterface

// File: rtl/mrd_rdx5_sched.sv
// Round-robin burst scheduler sharing one fixed-latency radix-5 engine between two requesters.
// A LAT-deep tag pipe tracks in-flight beats so results and exponents route back to the owner.
module mrd_rdx5_sched #(
    parameter int LAT   = 6,
    parameter int LEN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mrd_rdx5_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic v;
        logic id;
        logic last;
    } tag_t;

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 sel_q, sel_d;
    logic [1:0]           margin_q, margin_d;
    logic [3:0]           exp_q, exp_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 rr_q, rr_d;
    logic                 err_q, err_d;
    tag_t [LAT-1:0]       tag_q;
    tag_t                 tag_in, tag_out;
    logic                 elig0, elig1, pick1, in_val, fin;
    logic [1:0]           res_val;

    assign elig0   = bus.req[0] & (bus.req_len0 != '0);
    assign elig1   = bus.req[1] & (bus.req_len1 != '0);
    // Requester 1 wins when it is the only candidate, or on a tie while rr points at it.
    assign pick1   = elig1 & (~elig0 | rr_q);
    assign in_val  = (state_q == ISSUE) & bus.src_val[sel_q];
    assign tag_out = tag_q[LAT-1];
    assign fin     = tag_out.v & tag_out.last;
    assign tag_in  = '{v: in_val, id: sel_q, last: in_val & (cnt_q == LEN_W'(1))};

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        margin_d = margin_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        err_d    = err_q | (bus.eng_out_val != tag_out.v);
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    sel_d    = pick1;
                    gnt_d    = pick1 ? 2'b10 : 2'b01;
                    margin_d = pick1 ? bus.req_margin1 : bus.req_margin0;
                    exp_d    = pick1 ? bus.req_exp1 : bus.req_exp0;
                    cnt_d    = pick1 ? bus.req_len1 : bus.req_len0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (in_val) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fin) begin
                    gnt_d   = 2'b00;
                    rr_d    = ~tag_out.id;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= 1'b0;
            margin_q <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            margin_q <= margin_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            tag_q    <= {tag_q[LAT-2:0], tag_in};
        end
    end

    assign res_val        = (bus.eng_out_val & tag_out.v) ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.res_val    = res_val;
    assign bus.res_last   = res_val & {2{tag_out.last}};
    assign bus.done       = res_val & {2{tag_out.last}};
    assign bus.res_exp    = (|res_val) ? bus.eng_exp_out : 4'd0;
    assign bus.gnt        = gnt_q;
    assign bus.eng_in_val = in_val;
    assign bus.eng_sel    = sel_q;
    assign bus.eng_margin = margin_q;
    assign bus.eng_exp_in = exp_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.err_tag    = err_q;
endmodule

// File: tb/tb_mrd_rdx5_sched.sv
// Bench for mrd_rdx5_sched: a model engine with fixed latency, and a burst-timeline reference
// that predicts grants, accepted beats and result cycles for each scenario.
module tb_mrd_rdx5_sched;
    localparam int LAT   = 6;
    localparam int LEN_W = 8;
    localparam int N     = 1024;

    logic clk = 1'b0;
    logic rst_n;
    logic inj;
    always #5 clk = ~clk;

    mrd_rdx5_sched_if #(.LEN_W(LEN_W)) bus();
    mrd_rdx5_sched #(.LAT(LAT), .LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Model engine: valid and exp_in+1 delayed by LAT; inj forces a spurious output beat.
    logic [LAT-1:0]      dly;
    logic [LAT-1:0][3:0] dexp;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly  <= '0;
            dexp <= '0;
        end else begin
            dly  <= {dly[LAT-2:0], bus.eng_in_val};
            dexp <= {dexp[LAT-2:0], bus.eng_exp_in + 4'd1};
        end
    end
    assign bus.eng_out_val = dly[LAT-1] | inj;
    assign bus.eng_exp_out = inj ? 4'hA : dexp[LAT-1];

    logic [1:0] e_gnt [N];
    logic       e_inv [N];
    logic [1:0] e_rv  [N];
    logic [1:0] e_rl  [N];
    logic [3:0] e_rexp[N];
    logic       e_sel [N];
    logic [1:0] e_mar [N];
    logic [3:0] e_exp [N];
    logic [1:0] d_req [N];
    logic [1:0] d_src [N];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_rr, m_err;

    task automatic do_reset();
        logic [21:0] obs;
        rst_n = 1'b0; inj = 1'b0;
        bus.req = '0; bus.src_val = '0;
        bus.req_len0 = '0; bus.req_len1 = '0;
        bus.req_margin0 = '0; bus.req_margin1 = '0;
        bus.req_exp0 = '0; bus.req_exp1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_rr = 1'b0; m_err = 1'b0;
        @(negedge clk);
        obs = {bus.gnt, bus.busy, bus.eng_in_val, bus.res_val, bus.res_last, bus.done,
               bus.res_exp, bus.err_tag, bus.eng_sel, bus.eng_margin, bus.eng_exp_in};
        n_cmp++;
        assert (obs === 22'd0) else begin
            n_bad++;
            $error("FAIL reset_state observed=%h expected=%h", obs, 22'd0);
        end
    endtask

    // rq/l0/l1: requests and lengths; fixed selects pat (bit k = src_val k cycles into a grant);
    // inj_at: cycle of a spurious engine output; rst_back>0: reset that many cycles before the
    // final result of the last burst.
    task automatic scen(input string nm, input logic [1:0] rq, input int l0, input int l1,
                        input bit fixed, input logic [15:0] pat, input int inj_at,
                        input int rst_back);
        int         len[2];
        logic [1:0] mar[2];
        logic [3:0] ex[2];
        logic [1:0] pend;
        int         t, g, c, k, beats, w, dd, last_end, rst_at;
        bit         b;
        logic [14:0] obs, expv;
        logic [6:0]  obs2, exp2;
        len[0] = l0; len[1] = l1;
        for (int i = 0; i < 2; i++) begin
            mar[i] = 2'($urandom);
            ex[i]  = 4'($urandom);
        end
        bus.req_len0 = LEN_W'(l0); bus.req_len1 = LEN_W'(l1);
        bus.req_margin0 = mar[0]; bus.req_margin1 = mar[1];
        bus.req_exp0 = ex[0]; bus.req_exp1 = ex[1];
        for (int i = 0; i < N; i++) begin
            e_gnt[i] = '0; e_inv[i] = 1'b0; e_rv[i] = '0; e_rl[i] = '0; e_rexp[i] = '0;
            e_sel[i] = 1'b0; e_mar[i] = '0; e_exp[i] = '0;
            d_req[i] = rq; d_src[i] = 2'($urandom);
        end
        pend = rq & {l1 != 0, l0 != 0};
        t = 0; dd = -1;
        while (pend != 2'b00) begin
            w = (pend == 2'b11) ? int'(m_rr) : (pend[1] ? 1 : 0);
            g = t + 1; c = g; k = 0; beats = 0;
            while (beats < len[w]) begin
                if (fixed) b = (k < 16) ? pat[k] : 1'b1;
                else       b = ($urandom_range(0, 3) != 0) || (c > N - 4 * LAT);
                d_src[c][w] = b;
                if (b) begin
                    beats++;
                    e_inv[c] = 1'b1;
                    e_rv[c+LAT][w] = 1'b1;
                    e_rexp[c+LAT] = ex[w] + 4'd1;
                    if (beats == len[w]) e_rl[c+LAT][w] = 1'b1;
                end
                c++; k++;
            end
            dd = c - 1 + LAT;
            for (int i = g; i <= dd; i++) begin
                e_gnt[i][w] = 1'b1; e_sel[i] = (w == 1);
                e_mar[i] = mar[w]; e_exp[i] = ex[w];
            end
            for (int i = dd + 1; i < N; i++) d_req[i][w] = 1'b0;
            m_rr = (w == 0);
            pend[w] = 1'b0;
            t = dd + 1;
        end
        last_end = t + 2;
        rst_at = -1;
        if (rst_back > 0 && dd > 0) begin
            rst_at = dd - rst_back;
            for (int i = rst_at + 1; i < N; i++) begin
                e_gnt[i] = '0; e_inv[i] = 1'b0; e_rv[i] = '0; e_rl[i] = '0; e_rexp[i] = '0;
                d_req[i] = '0;
            end
            last_end = rst_at + LAT + 3;
            m_rr = 1'b0;
        end
        for (int cy = 0; cy <= last_end; cy++) begin
            @(posedge clk);
            #1;
            rst_n = (cy == rst_at) ? 1'b0 : 1'b1;
            if (cy == inj_at + 1 && inj_at >= 0) m_err = 1'b1;
            if (cy == rst_at + 1 && rst_at >= 0) m_err = 1'b0;
            bus.req = d_req[cy];
            bus.src_val = d_src[cy];
            inj = (cy == inj_at);
            @(negedge clk);
            if (cy != rst_at) begin
                obs  = {bus.gnt, bus.busy, bus.eng_in_val, bus.res_val, bus.res_last, bus.done,
                        bus.res_exp, bus.err_tag};
                expv = {e_gnt[cy], |e_gnt[cy], e_inv[cy], e_rv[cy], e_rl[cy], e_rl[cy],
                        e_rexp[cy], m_err};
                n_cmp++;
                assert (obs === expv) else begin
                    n_bad++;
                    $error("FAIL %s cyc%0d outputs observed=%h expected=%h", nm, cy, obs, expv);
                end
                if (e_gnt[cy] != 2'b00) begin
                    obs2 = {bus.eng_sel, bus.eng_margin, bus.eng_exp_in};
                    exp2 = {e_sel[cy], e_mar[cy], e_exp[cy]};
                    n_cmp++;
                    assert (obs2 === exp2) else begin
                        n_bad++;
                        $error("FAIL %s cyc%0d sel_margin_exp observed=%h expected=%h",
                               nm, cy, obs2, exp2);
                    end
                end
            end
        end
        inj = 1'b0;
        bus.req = '0;
        bus.src_val = '0;
    endtask

    initial begin
        do_reset();
        scen("t2_both_len2",   2'b11, 2, 2, 1'b1, 16'hFFFF, -1, 0);
        scen("t1_req0_len4",   2'b01, 4, 0, 1'b1, 16'hFFFF, -1, 0);
        scen("t3_req1_gaps",   2'b10, 0, 3, 1'b1, 16'h0019, -1, 0);
        scen("t4_len0_skip",   2'b11, 0, 1, 1'b1, 16'hFFFF, -1, 0);
        for (int r = 0; r < 8; r++)
            scen("rand", 2'($urandom_range(1, 3)), $urandom_range(0, 12),
                 $urandom_range(0, 12), 1'b0, 16'h0000, -1, 0);
        scen("t6_spurious",    2'b01, 5, 0, 1'b0, 16'h0000, 0, 0);
        scen("t6_after_err",   2'b11, 3, 4, 1'b0, 16'h0000, -1, 0);
        scen("t5_rst_drain",   2'b11, 3, 3, 1'b0, 16'h0000, -1, 2);
        scen("post_reset",     2'b11, 2, 5, 1'b0, 16'h0000, -1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
